// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw PS/2 lines, decodes 11-bit frames,
// and keeps a two-byte history of received scan codes.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          strike;

  state_e        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_ok;
  logic [TW-1:0] tcnt;
  logic          timeout;

  // Everything resets high so that releasing reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign strike  = filt_prev & ~filt_clk;
  assign timeout = !strike && (state != StIdle) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      tcnt      <= '0;
      key       <= 16'h0000;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;

      if (strike || state == StIdle) begin
        tcnt <= '0;
      end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + 1'b1;
      end

      if (timeout) begin
        state     <= StIdle;
        bit_cnt   <= '0;
        shift     <= '0;
        frame_err <= 1'b1;
      end else if (strike) begin
        unique case (state)
          StIdle: begin
            if (!dat_s2) begin
              state   <= StData;
              bit_cnt <= '0;
            end
          end
          StData: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= StParity;
          end
          StParity: begin
            parity_ok <= ^{dat_s2, shift};
            state     <= StStop;
          end
          StStop: begin
            if (dat_s2 && parity_ok) begin
              key       <= {key[7:0], shift};
              key_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive identical synchronized ps2_clk samples required to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: idle clk cycles inside a frame before the frame is abandoned (1 ms at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw keyboard clock, asynchronous, idle high.
REQ-006 ps2_data  input  1  raw keyboard data, asynchronous, idle high.
REQ-007 key  output  16  scan-code history: key[7:0] = newest byte, key[15:8] = previous byte.
REQ-008 key_valid  output  1  one-cycle pulse, asserted in the same cycle key changes.
REQ-009 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples disagree with its current level; shorter glitches SHALL be ignored.
REQ-012 A falling edge of the filtered clock SHALL produce a one-cycle internal sample strike; synchronized ps2_data SHALL be sampled in that cycle.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on strike with data 0 (start bit) -> DATA, bit count 0; strike with data 1 -> stay IDLE, no error.
REQ-015 DATA: each strike shifts data into an 8-bit register LSB-first; after the 8th bit -> PARITY.
REQ-016 PARITY: on strike, record parity OK when the 8 data bits plus parity bit hold an odd number of 1s; -> STOP.
REQ-017 STOP: on strike, if stop bit = 1 and parity OK, the cycle after the strike SHALL load key <= {key[7:0], byte} and pulse key_valid; otherwise pulse frame_err, leave key unchanged; either way -> IDLE.
REQ-018 key_valid and frame_err SHALL never be asserted in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-019 A timeout counter SHALL clear on every strike and in IDLE; in DATA, PARITY or STOP, when it reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, discard partial data and pulse frame_err once.
REQ-020 Timeout counter width SHALL hold TIMEOUT_CYCLES without wrap; it SHALL saturate rather than wrap.
REQ-021 Break (F0) and extended (E0) prefixes SHALL be delivered as ordinary bytes; no interpretation of scan codes is done here.
REQ-022 The block is receive-only: it SHALL never drive ps2_clk or ps2_data.
REQ-023 Consecutive frames with no idle gap (next start bit on the strike immediately following a stop bit) SHALL be received without loss.

Reset
REQ-024 While reset is high on a clk edge: FSM -> IDLE, bit count, shift register, timeout counter cleared; key = 16'h0000, key_valid = 0, frame_err = 0.
REQ-025 Synchronizer flops and filtered clock SHALL reset to 1 (idle-high), so no strike is generated on reset release.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no key_valid and no frame_err; remaining bits of that frame after release SHALL be treated per REQ-014 (data-1 bits ignored; a data-0 bit starts a new, usually erroneous, frame).

Verification
REQ-027 Send byte 8'h29 (start 0, LSB-first 1,0,0,1,0,1,0,0, parity 0, stop 1) at 12.5 kHz from key = 0 -> exactly one key_valid, key = 16'h0029, no frame_err.
REQ-028 Send 8'hF0 then 8'h29 back-to-back -> two key_valid pulses, key = 16'hF029 after the second.
REQ-029 Send 8'h1C with parity bit inverted -> one frame_err pulse, no key_valid, key unchanged.
REQ-030 Send start bit plus 4 data bits then hold ps2_clk high for 1.1 ms -> one frame_err after TIMEOUT_CYCLES, FSM IDLE; a following valid 8'h5A yields key[7:0] = 8'h5A.
REQ-031 Inject 3-cycle low glitches on ps2_clk during a valid 8'h29 frame -> no extra bits, key[7:0] = 8'h29, no frame_err.
REQ-032 Assert reset for 2 cycles after the 5th data bit of 8'h29 -> key = 16'h0000, no pulses; next complete 8'h76 frame -> key = 16'h0076.
